// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction/address widths and the fetch-queue entry payload.
package cpu_pkg;

  localparam int unsigned IW = 9;
  localparam int unsigned AW = 9;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// Circular entry store for the fetch queue: register array plus head/tail pointers.
module fq_ring
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  fq_entry_t wr_data,
  input  logic      rd_adv,
  input  logic      clr,
  output fq_entry_t rd_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  // Pointer wrap is implicit because DEPTH is a power of two; clear wins over advance.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (wr_en) begin
      mem_d[tail_q] = wr_data;
      tail_d        = tail_q + PW'(1);
    end
    if (rd_adv) begin
      head_d = head_q + PW'(1);
    end
    if (clr) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign rd_data = mem_q[head_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: drives the ROM address, queues {pc, instr} entries
// and hands the oldest one to decode, with flush (jump) and halt control.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = cpu_pkg::IW,
  parameter int unsigned AW    = cpu_pkg::AW
) (
  input  logic                       clk,
  input  logic                       start,
  input  logic                       halt,
  input  logic                       flush_en,
  input  logic [AW-1:0]              flush_target,
  output logic [AW-1:0]              rom_addr,
  input  logic [IW-1:0]              rom_data,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [IW-1:0]              deq_instr,
  output logic [AW-1:0]              deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  import cpu_pkg::fq_entry_t;

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          fetch_do;
  logic          deq_do;
  fq_entry_t     wr_entry;
  fq_entry_t     head_entry;

  assign deq_valid = (count_q != '0);
  assign deq_do    = deq_valid && deq_ready;

  // Flush beats fetch; a dequeue in the flush cycle is still honoured (it consumes the jump).
  always_comb begin
    fetch_do       = !halt && !flush_en && ((count_q < CW'(DEPTH)) || deq_do);
    wr_entry.pc    = fetch_pc_q;
    wr_entry.instr = rom_data;
    fetch_pc_d     = fetch_pc_q;
    count_d        = count_q + CW'(fetch_do) - CW'(deq_do);
    if (fetch_do) begin
      fetch_pc_d = fetch_pc_q + AW'(1);
    end
    if (flush_en) begin
      fetch_pc_d = flush_target;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      fetch_pc_q <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
    end
  end

  fq_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (start),
    .wr_en   (fetch_do),
    .wr_data (wr_entry),
    .rd_adv  (deq_do),
    .clr     (flush_en),
    .rd_data (head_entry)
  );

  assign rom_addr  = fetch_pc_q;
  assign deq_instr = head_entry.instr;
  assign deq_pc    = head_entry.pc;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an identity ROM (word[a] = a).
module tb_fetch_queue;

  logic       clk = 1'b0;
  logic       start;
  logic       halt;
  logic       flush_en;
  logic [8:0] flush_target;
  logic [8:0] rom_addr;
  logic [8:0] rom_data;
  logic       deq_ready;
  logic       deq_valid;
  logic [8:0] deq_instr;
  logic [8:0] deq_pc;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_addr;

  fetch_queue #(
    .DEPTH (4),
    .IW    (9),
    .AW    (9)
  ) dut (
    .clk          (clk),
    .start        (start),
    .halt         (halt),
    .flush_en     (flush_en),
    .flush_target (flush_target),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .deq_ready    (deq_ready),
    .deq_valid    (deq_valid),
    .deq_instr    (deq_instr),
    .deq_pc       (deq_pc),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b1;
    #2;
    start = 1'b0;
  endtask

  // Occupancy bound, sampled away from the active edge.
  always @(negedge clk) begin
    if (!start) begin
      checks++;
      assert (count <= 3'd4)
      else begin
        errors++;
        $error("FAIL count_bound: observed %0d expected <= 4", count);
      end
    end
  end

  initial begin
    start        = 1'b1;
    halt         = 1'b0;
    flush_en     = 1'b0;
    flush_target = '0;
    deq_ready    = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(deq_valid), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_deq_pc", 32'(deq_pc), 32'd0);
    chk("rst_deq_instr", 32'(deq_instr), 32'd0);
    step();
    start = 1'b0;

    // Streaming: no bypass, then one entry per cycle in PC order.
    chk("stream_valid0", 32'(deq_valid), 32'd0);
    step();
    chk("stream_first_valid", 32'(deq_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("stream_pc", 32'(deq_pc), 32'(i));
      chk("stream_instr", 32'(deq_instr), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
      step();
    end

    // Back-pressure: fill to 4, then drain with full-rate refill.
    do_reset();
    deq_ready = 1'b0;
    repeat (10) step();
    chk("full_count", 32'(count), 32'd4);
    chk("full_rom_addr", 32'(rom_addr), 32'd4);
    chk("full_head_pc", 32'(deq_pc), 32'd0);
    deq_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      step();
      chk("full_drain_pc", 32'(deq_pc), 32'(i));
      chk("full_drain_count", 32'(count), 32'd4);
      chk("full_drain_valid", 32'(deq_valid), 32'd1);
    end

    // Flush with 3 entries queued.
    do_reset();
    deq_ready = 1'b0;
    repeat (3) step();
    chk("pre_flush_count", 32'(count), 32'd3);
    flush_en     = 1'b1;
    flush_target = 9'h1F0;
    step();
    flush_en = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(deq_valid), 32'd0);
    chk("flush_rom_addr", 32'(rom_addr), 32'h1F0);
    step();
    chk("flush_tgt_valid", 32'(deq_valid), 32'd1);
    chk("flush_tgt_pc", 32'(deq_pc), 32'h1F0);
    chk("flush_tgt_instr", 32'(deq_instr), 32'h1F0);
    deq_ready = 1'b1;
    step();
    chk("flush_next_pc", 32'(deq_pc), 32'h1F1);

    // Flush with a concurrent dequeue and PC wrap.
    flush_en     = 1'b1;
    flush_target = 9'h1FE;
    step();
    flush_en = 1'b0;
    chk("wrap_flush_valid", 32'(deq_valid), 32'd0);
    step();
    chk("wrap_pc0", 32'(deq_pc), 32'h1FE);
    step();
    chk("wrap_pc1", 32'(deq_pc), 32'h1FF);
    step();
    chk("wrap_pc2", 32'(deq_pc), 32'h000);
    chk("wrap_instr2", 32'(deq_instr), 32'h000);

    // Halt with 2 queued entries: drain, hold fetch_pc, then resume.
    do_reset();
    deq_ready = 1'b0;
    repeat (2) step();
    chk("halt_pre_count", 32'(count), 32'd2);
    halt      = 1'b1;
    deq_ready = 1'b1;
    step();
    chk("halt_count1", 32'(count), 32'd1);
    chk("halt_pc1", 32'(deq_pc), 32'd1);
    chk("halt_rom_addr1", 32'(rom_addr), 32'd2);
    step();
    chk("halt_valid_drop", 32'(deq_valid), 32'd0);
    chk("halt_rom_addr2", 32'(rom_addr), 32'd2);
    step();
    chk("halt_rom_addr3", 32'(rom_addr), 32'd2);
    chk("halt_count3", 32'(count), 32'd0);
    halt = 1'b0;
    step();
    chk("resume_valid", 32'(deq_valid), 32'd1);
    chk("resume_pc", 32'(deq_pc), 32'd2);

    // Flush during halt redirects without fetching.
    halt         = 1'b1;
    flush_en     = 1'b1;
    flush_target = 9'h050;
    step();
    flush_en = 1'b0;
    chk("halt_flush_count", 32'(count), 32'd0);
    chk("halt_flush_rom_addr", 32'(rom_addr), 32'h050);
    step();
    chk("halt_flush_hold", 32'(count), 32'd0);
    halt = 1'b0;
    step();
    chk("halt_flush_pc", 32'(deq_pc), 32'h050);

    // Asynchronous reset mid-stream, away from the clock edge.
    step();
    #2;
    start = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_rom_addr", 32'(rom_addr), 32'd0);
    chk("async_valid", 32'(deq_valid), 32'd0);
    chk("async_deq_pc", 32'(deq_pc), 32'd0);
    step();
    start = 1'b0;
    step();
    chk("post_async_pc", 32'(deq_pc), 32'd0);
    chk("post_async_valid", 32'(deq_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
